// File: rtl/bolme_carpma_cikarma_if.sv
// Start/operand/result bundle between the calculator top level and the
// subtract/multiply/divide engine.
interface bolme_carpma_cikarma_if;
   logic        basla;
   logic [2:0]  tur;
   logic [31:0] sayi1;
   logic [31:0] sayi2;
   logic [63:0] sonuc;
   logic        hazir;
   logic        gecerli;
   logic        tasma;

   modport master (output basla, tur, sayi1, sayi2,
                   input  sonuc, hazir, gecerli, tasma);
   modport slave  (input  basla, tur, sayi1, sayi2,
                   output sonuc, hazir, gecerli, tasma);
endinterface

// File: rtl/bolme_carpma_cikarma.sv
// Sequential signed subtract / shift-add multiply / restoring divide engine.
//   state | meaning
//   IDLE  | hazir=1, result stable, basla accepted
//   BUSY  | operation in flight, basla ignored
module bolme_carpma_cikarma (
   input  logic                    clk,
   input  logic                    rst,
   bolme_carpma_cikarma_if.slave   bus
);
   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;

   state_t      r_state;
   logic [2:0]  r_op;
   logic        r_dz;
   logic [5:0]  r_cnt;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [63:0] r_mcand;
   logic [31:0] r_b_mag;
   logic [63:0] r_prod;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic        r_neg_q;
   logic        r_neg_r;
   logic [63:0] r_sonuc;
   logic        r_hazir;
   logic        r_gecerli;
   logic        r_tasma;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [63:0] w_diff;
   logic        w_diff_ovf;
   logic [63:0] w_prod_nx;
   logic [63:0] w_prod_sg;
   logic        w_prod_ovf;
   logic [32:0] w_shift;
   logic        w_ge;
   logic [31:0] w_trial;
   logic [31:0] w_q_sg;
   logic [31:0] w_r_sg;

   // |-2^31| wraps to 32'h8000_0000, which is the correct unsigned magnitude
   assign w_a_mag    = bus.sayi1[31] ? (~bus.sayi1 + 32'd1) : bus.sayi1;
   assign w_b_mag    = bus.sayi2[31] ? (~bus.sayi2 + 32'd1) : bus.sayi2;

   assign w_diff     = {{32{r_a[31]}}, r_a} - {{32{r_b[31]}}, r_b};
   assign w_diff_ovf = (w_diff[63:31] != {33{w_diff[31]}});

   assign w_prod_nx  = r_prod + (r_b_mag[0] ? r_mcand : 64'd0);
   assign w_prod_sg  = r_neg_q ? (~w_prod_nx + 64'd1) : w_prod_nx;
   assign w_prod_ovf = (w_prod_sg[63:31] != {33{w_prod_sg[31]}});

   assign w_shift    = {r_rem, r_quo[31]};
   assign w_ge       = (w_shift >= {1'b0, r_b_mag});
   assign w_trial    = w_shift[31:0] - r_b_mag;
   assign w_q_sg     = r_neg_q ? (~r_quo + 32'd1) : r_quo;
   assign w_r_sg     = r_neg_r ? (~r_rem + 32'd1) : r_rem;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_op      <= 3'd0;
         r_dz      <= 1'b0;
         r_cnt     <= 6'd0;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_mcand   <= 64'd0;
         r_b_mag   <= 32'd0;
         r_prod    <= 64'd0;
         r_rem     <= 32'd0;
         r_quo     <= 32'd0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_sonuc   <= 64'd0;
         r_hazir   <= 1'b1;
         r_gecerli <= 1'b0;
         r_tasma   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.basla) begin
                  r_state <= BUSY;
                  r_hazir <= 1'b0;
                  r_op    <= bus.tur;
                  r_a     <= bus.sayi1;
                  r_b     <= bus.sayi2;
                  r_mcand <= {32'd0, w_a_mag};
                  r_b_mag <= w_b_mag;
                  r_quo   <= w_a_mag;
                  r_rem   <= 32'd0;
                  r_prod  <= 64'd0;
                  r_neg_q <= bus.sayi1[31] ^ bus.sayi2[31];
                  r_neg_r <= bus.sayi1[31];
                  r_dz    <= (bus.sayi2 == 32'd0);
                  r_cnt   <= (bus.tur == OP_MUL) ? 6'd31 : 6'd32;
               end
            end
            BUSY: begin
               case (r_op)
                  OP_SUB: begin
                     r_sonuc   <= w_diff;
                     r_gecerli <= 1'b1;
                     r_tasma   <= w_diff_ovf;
                     r_state   <= IDLE;
                     r_hazir   <= 1'b1;
                  end
                  OP_MUL: begin
                     r_prod  <= w_prod_nx;
                     r_mcand <= r_mcand << 1;
                     r_b_mag <= r_b_mag >> 1;
                     if (r_cnt == 6'd0) begin
                        r_sonuc   <= w_prod_sg;
                        r_gecerli <= 1'b1;
                        r_tasma   <= w_prod_ovf;
                        r_state   <= IDLE;
                        r_hazir   <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt - 6'd1;
                     end
                  end
                  OP_DIV: begin
                     if (r_dz) begin
                        r_sonuc   <= 64'd0;
                        r_gecerli <= 1'b0;
                        r_tasma   <= 1'b0;
                        r_state   <= IDLE;
                        r_hazir   <= 1'b1;
                     end else if (r_cnt != 6'd0) begin
                        r_rem <= w_ge ? w_trial : w_shift[31:0];
                        r_quo <= {r_quo[30:0], w_ge};
                        r_cnt <= r_cnt - 6'd1;
                     end else begin
                        // a positive quotient with bit 31 set only arises from -2^31 / -1
                        r_sonuc   <= {w_r_sg, w_q_sg};
                        r_gecerli <= 1'b1;
                        r_tasma   <= ~r_neg_q & r_quo[31];
                        r_state   <= IDLE;
                        r_hazir   <= 1'b1;
                     end
                  end
                  default: begin
                     r_sonuc   <= 64'd0;
                     r_gecerli <= 1'b0;
                     r_tasma   <= 1'b0;
                     r_state   <= IDLE;
                     r_hazir   <= 1'b1;
                  end
               endcase
            end
            default: begin
               r_state <= IDLE;
               r_hazir <= 1'b1;
            end
         endcase
      end
   end

   assign bus.sonuc   = r_sonuc;
   assign bus.hazir   = r_hazir;
   assign bus.gecerli = r_gecerli;
   assign bus.tasma   = r_tasma;
endmodule

// File: tb/tb_bolme_carpma_cikarma.sv
// Directed bench for the subtract/multiply/divide engine: latency, results and flags.
module tb_bolme_carpma_cikarma;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   bolme_carpma_cikarma_if bus ();

   bolme_carpma_cikarma dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // launches one operation and counts edges from accept until hazir returns
   task automatic do_op(input logic [2:0] t, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
      @(negedge clk);
      bus.basla = 1'b1;
      bus.tur   = t;
      bus.sayi1 = a;
      bus.sayi2 = b;
      @(posedge clk);
      #1;
      bus.basla = 1'b0;
      lat = 0;
      while (!bus.hazir && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst       = 1'b0;
      bus.basla = 1'b0;
      bus.tur   = 3'b000;
      bus.sayi1 = 32'd0;
      bus.sayi2 = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b1 || bus.sonuc !== 64'd0 || bus.gecerli !== 1'b0 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL reset: got hazir=%b sonuc=%h gecerli=%b tasma=%b want 1/0/0/0",
                  bus.hazir, bus.sonuc, bus.gecerli, bus.tasma);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_subtract();
      int lat;
      do_op(3'b001, 32'd5, 32'd7, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL sub_lat: got %0d want 1", lat); end
      checks++;
      if (bus.sonuc !== 64'hFFFF_FFFF_FFFF_FFFE || bus.gecerli !== 1'b1 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL sub_5_7: got %h g=%b t=%b want fffffffffffffffe g=1 t=0", bus.sonuc, bus.gecerli, bus.tasma);
      end
      do_op(3'b001, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat);
      checks++;
      if (bus.sonuc !== 64'h0000_0000_8000_0000 || bus.gecerli !== 1'b1 || bus.tasma !== 1'b1) begin
         errors++;
         $display("FAIL sub_ovf: got %h g=%b t=%b want 0000000080000000 g=1 t=1", bus.sonuc, bus.gecerli, bus.tasma);
      end
      do_op(3'b001, 32'h8000_0000, 32'd0, lat);
      checks++;
      if (bus.sonuc !== 64'hFFFF_FFFF_8000_0000 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL sub_min: got %h t=%b want ffffffff80000000 t=0", bus.sonuc, bus.tasma);
      end
   endtask

   task automatic test_multiply();
      int lat;
      do_op(3'b010, 32'hFFFF_FFFD, 32'd7, lat);
      checks++;
      if (lat !== 32) begin errors++; $display("FAIL mul_lat: got %0d want 32", lat); end
      checks++;
      if (bus.sonuc !== 64'hFFFF_FFFF_FFFF_FFEB || bus.gecerli !== 1'b1 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL mul_m3_7: got %h g=%b t=%b want ffffffffffffffeb g=1 t=0", bus.sonuc, bus.gecerli, bus.tasma);
      end
      do_op(3'b010, 32'h0001_0000, 32'h0001_0000, lat);
      checks++;
      if (bus.sonuc !== 64'h0000_0001_0000_0000 || bus.tasma !== 1'b1) begin
         errors++;
         $display("FAIL mul_big: got %h t=%b want 0000000100000000 t=1", bus.sonuc, bus.tasma);
      end
      do_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      checks++;
      if (bus.sonuc !== 64'h0000_0000_8000_0000 || bus.tasma !== 1'b1) begin
         errors++;
         $display("FAIL mul_min_m1: got %h t=%b want 0000000080000000 t=1", bus.sonuc, bus.tasma);
      end
      do_op(3'b010, 32'h8000_0000, 32'd1, lat);
      checks++;
      if (bus.sonuc !== 64'hFFFF_FFFF_8000_0000 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL mul_min_1: got %h t=%b want ffffffff80000000 t=0", bus.sonuc, bus.tasma);
      end
   endtask

   task automatic test_divide();
      int lat;
      do_op(3'b011, 32'd7, 32'hFFFF_FFFE, lat);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL div_lat: got %0d want 33", lat); end
      checks++;
      if (bus.sonuc !== 64'h0000_0001_FFFF_FFFD || bus.gecerli !== 1'b1 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL div_7_m2: got %h g=%b t=%b want 00000001fffffffd g=1 t=0", bus.sonuc, bus.gecerli, bus.tasma);
      end
      do_op(3'b011, 32'hFFFF_FFF9, 32'd2, lat);
      checks++;
      if (bus.sonuc !== 64'hFFFF_FFFF_FFFF_FFFD) begin
         errors++;
         $display("FAIL div_m7_2: got %h want fffffffffffffffd", bus.sonuc);
      end
      do_op(3'b011, 32'd100, 32'd0, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL div0_lat: got %0d want 1", lat); end
      checks++;
      if (bus.sonuc !== 64'd0 || bus.gecerli !== 1'b0 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL div0: got %h g=%b t=%b want 0 g=0 t=0", bus.sonuc, bus.gecerli, bus.tasma);
      end
      do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      checks++;
      if (bus.sonuc !== 64'h0000_0000_8000_0000 || bus.gecerli !== 1'b1 || bus.tasma !== 1'b1) begin
         errors++;
         $display("FAIL div_ovf: got %h g=%b t=%b want 0000000080000000 g=1 t=1", bus.sonuc, bus.gecerli, bus.tasma);
      end
   endtask

   task automatic test_invalid();
      int lat;
      do_op(3'b111, 32'd12, 32'd3, lat);
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL inv_lat: got %0d want 1", lat); end
      checks++;
      if (bus.sonuc !== 64'd0 || bus.gecerli !== 1'b0 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL invalid: got %h g=%b t=%b want 0 g=0 t=0", bus.sonuc, bus.gecerli, bus.tasma);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      bus.basla = 1'b1;
      bus.tur   = 3'b001;
      bus.sayi1 = 32'd3;
      bus.sayi2 = 32'd1;
      @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b0) begin errors++; $display("FAIL b2b_accept: got hazir=%b want 0", bus.hazir); end
      @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b1 || bus.sonuc !== 64'd2) begin
         errors++;
         $display("FAIL b2b_done: got hazir=%b sonuc=%h want 1/2", bus.hazir, bus.sonuc);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b0) begin errors++; $display("FAIL b2b_reaccept: got hazir=%b want 0", bus.hazir); end
      @(negedge clk);
      bus.basla = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b1 || bus.sonuc !== 64'd2 || bus.gecerli !== 1'b1) begin
         errors++;
         $display("FAIL b2b_second: got hazir=%b sonuc=%h g=%b want 1/2/1", bus.hazir, bus.sonuc, bus.gecerli);
      end
   endtask

   task automatic test_abort();
      int lat;
      @(negedge clk);
      bus.basla = 1'b1;
      bus.tur   = 3'b010;
      bus.sayi1 = 32'd1234;
      bus.sayi2 = 32'd5678;
      @(posedge clk);
      #1;
      bus.basla = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         bus.basla = (i == 4);
         if (i == 4) begin
            bus.tur   = 3'b001;
            bus.sayi1 = 32'd77;
            bus.sayi2 = 32'd11;
         end
         if (i == 10) begin
            checks++;
            if (bus.hazir !== 1'b0 || bus.sonuc !== 64'd2) begin
               errors++;
               $display("FAIL abort_busy: got hazir=%b sonuc=%h want 0/2", bus.hazir, bus.sonuc);
            end
            rst = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.hazir !== 1'b1 || bus.sonuc !== 64'd0 || bus.gecerli !== 1'b0 || bus.tasma !== 1'b0) begin
         errors++;
         $display("FAIL abort_rst: got hazir=%b sonuc=%h g=%b t=%b want 1/0/0/0",
                  bus.hazir, bus.sonuc, bus.gecerli, bus.tasma);
      end
      @(negedge clk);
      rst = 1'b1;
      do_op(3'b001, 32'd9, 32'd4, lat);
      checks++;
      if (lat !== 1 || bus.sonuc !== 64'd5 || bus.gecerli !== 1'b1) begin
         errors++;
         $display("FAIL after_abort: got lat=%0d sonuc=%h g=%b want 1/5/1", lat, bus.sonuc, bus.gecerli);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_subtract();
      test_multiply();
      test_divide();
      test_invalid();
      test_back_to_back();
      test_abort();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bolme_carpma_cikarma.md
# bolme_carpma_cikarma

Sequential signed arithmetic unit that performs subtraction, multiplication and division of two 32-bit operands selected by an operation code. It is the subtract/multiply/divide engine behind the calculator top level. Each operation is launched with a start pulse. The result is reported with ready, valid and overflow flags.

## Interface
- No parameters.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-low reset.
- basla  input  1  start request; sampled only while hazir=1.
- tur  input  3  operation code: 3'b001 subtract, 3'b010 multiply, 3'b011 divide; any other code is invalid.
- sayi1  input  32  operand A, two's complement (minuend / multiplicand / dividend).
- sayi2  input  32  operand B, two's complement (subtrahend / multiplier / divisor).
- sonuc  output  64  result; held until the next completion.
- hazir  output  1  high when idle, result stable and a new start can be accepted.
- gecerli  output  1  the last completed operation produced a defined result.
- tasma  output  1  the last result does not fit in 32-bit signed (subtract/multiply) or the quotient overflowed (divide).

## Operation
- States: IDLE (hazir=1) and BUSY (hazir=0).
- In IDLE, basla=1 latches sayi1, sayi2 and tur, moves to BUSY and drops hazir. Inputs are don't-care while BUSY.
- basla while BUSY is ignored. No queueing.
- **Subtract:** sonuc = sign-extended 64-bit A−B. tasma=1 when the result lies outside [−2^31, 2^31−1]. gecerli=1.
- **Multiply:** magnitudes |A| and |B| are taken at accept; the |−2^31| case is 2^31 as unsigned. 32 iterations of unsigned shift-add form a 64-bit product. The product is negated on the final iteration if the signs differ. sonuc = full 64-bit signed product. tasma=1 when the product is outside the 32-bit signed range. gecerli=1.
- **Divide:** truncating signed division. 32 iterations of unsigned restoring division on the magnitudes, then one sign-fixup cycle.
  - Quotient sign = sign(A) xor sign(B); remainder sign = sign(A).
  - sonuc[31:0] = quotient, sonuc[63:32] = remainder.
  - B=0: sonuc=0, gecerli=0, tasma=0, no iterations.
  - A=−2^31, B=−1: sonuc[31:0]=32'h8000_0000, remainder 0, tasma=1, gecerli=1.
  - Otherwise tasma=0, gecerli=1.
- **Invalid tur:** sonuc=0, gecerli=0, tasma=0.
- sonuc, gecerli and tasma update only on the completion edge and hold until the next completion or reset.

## Timing
- **Reset** (rst=0 at a rising edge): state IDLE, hazir=1, sonuc=0, gecerli=0, tasma=0. Internal registers are cleared.
- Reset has priority over basla and aborts any BUSY operation; no partial result appears on the outputs.
- Start accepted at edge k. Completion edge, at which results are written and hazir returns to 1:
  - Subtract, invalid tur, divide by zero: k+1.
  - Multiply: k+32.
  - Divide: k+33.
- basla sampled high at the completion edge is not accepted, because hazir is low at that edge. The earliest next accept is the following edge.
- Back-to-back operations therefore take latency+1 cycles per operation.
- Outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset, then subtract A=5, B=7 -> after 1 cycle sonuc=64'hFFFF_FFFF_FFFF_FFFE, gecerli=1, tasma=0, hazir=1.
- Subtract A=32'h7FFF_FFFF, B=32'hFFFF_FFFF (−1) -> sonuc=64'h0000_0000_8000_0000, tasma=1, gecerli=1.
- Multiply A=−3, B=7 -> hazir low for exactly 32 cycles, sonuc=64'hFFFF_FFFF_FFFF_FFEB, tasma=0. Then multiply A=B=32'h0001_0000 -> sonuc=64'h0000_0001_0000_0000, tasma=1.
- Divide A=7, B=−2 -> after 33 cycles sonuc=64'h0000_0001_FFFF_FFFD. Then divide A=100, B=0 -> after 1 cycle sonuc=0, gecerli=0, tasma=0.
- Divide A=32'h8000_0000, B=−1 -> sonuc[31:0]=32'h8000_0000, tasma=1, gecerli=1. Then tur=3'b111 -> gecerli=0 after 1 cycle.
- Start a multiply, pulse basla with new operands mid-operation (ignored), assert rst=0 at cycle 10 -> next edge hazir=1, sonuc=0, gecerli=0, tasma=0. A subsequent subtract 9−4 returns sonuc=5.
